// File: rtl/seven_seg_pkg.sv
// Shared constants and helpers for the four-digit seven-segment scan controller.
package seven_seg_pkg;

    localparam int          NUM_DIGITS = 4;
    localparam logic [3:0]  AN_ALL_OFF = 4'b1111;
    localparam logic [3:0]  BCD_MAX    = 4'd9;

    // Active-low one-hot anode pattern for a lit slot.
    function automatic logic [3:0] slot_to_an(input logic [1:0] slot);
        return ~(4'b0001 << slot);
    endfunction

endpackage

// File: rtl/refresh_prescaler.sv
// Free-running divider: counts 0..DIV-1 and asserts tick on the last count.
module refresh_prescaler #(
    parameter int DIV = 100000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        tick    = (count_q == CW'(DIV - 1));
        count_d = tick ? '0 : count_q + CW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/seven_seg_scanner.sv
// Four-digit scan controller: double-buffered frame, leading-zero / invalid-code
// blanking, per-digit blink, and registered slot outputs updated on each tick.
module seven_seg_scanner
    import seven_seg_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLINK_FRAMES = 125
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] digits_in,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  blink_in,
    input  logic        lz_blank,
    input  logic        load,
    output logic [3:0]  bcd_out,
    output logic        blank_out,
    output logic        dp_out,
    output logic [3:0]  an,
    output logic        frame_start
);

    localparam int FCW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic tick;
    logic boundary;

    logic [1:0]     idx_q, idx_d;
    logic [15:0]    pend_digits_q, pend_digits_d;
    logic [3:0]     pend_dp_q, pend_dp_d;
    logic [3:0]     pend_blink_q, pend_blink_d;
    logic           pend_valid_q, pend_valid_d;
    logic [15:0]    act_digits_q, act_digits_d;
    logic [3:0]     act_dp_q, act_dp_d;
    logic [3:0]     act_blink_q, act_blink_d;
    logic [FCW-1:0] frame_cnt_q, frame_cnt_d;
    logic           phase_q, phase_d;
    logic           frame_phase_q, frame_phase_d;
    logic [3:0]     bcd_q, bcd_d;
    logic           blank_q, blank_d;
    logic           dp_q, dp_d;
    logic [3:0]     an_q, an_d;
    logic           frame_start_q, frame_start_d;

    logic [3:0]     nib;
    logic           upper_zero;
    logic           slot_blank;

    refresh_prescaler #(
        .DIV (REFRESH_DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst  (reset),
        .tick (tick)
    );

    assign boundary = tick && (idx_q == 2'd3);

    always_comb begin
        idx_d         = idx_q;
        pend_digits_d = pend_digits_q;
        pend_dp_d     = pend_dp_q;
        pend_blink_d  = pend_blink_q;
        pend_valid_d  = pend_valid_q;
        act_digits_d  = act_digits_q;
        act_dp_d      = act_dp_q;
        act_blink_d   = act_blink_q;
        frame_cnt_d   = frame_cnt_q;
        phase_d       = phase_q;
        frame_phase_d = frame_phase_q;
        bcd_d         = bcd_q;
        blank_d       = blank_q;
        dp_d          = dp_q;
        an_d          = an_q;
        frame_start_d = 1'b0;
        nib           = 4'd0;
        upper_zero    = 1'b1;
        slot_blank    = 1'b0;

        if (load) begin
            pend_digits_d = digits_in;
            pend_dp_d     = dp_in;
            pend_blink_d  = blink_in;
            pend_valid_d  = 1'b1;
        end

        if (tick) begin
            idx_d = idx_q + 2'd1;
        end

        if (boundary) begin
            frame_start_d = 1'b1;
            // The frame now starting blinks with the phase accumulated over the
            // boundaries before it; the counter then advances for the next frame.
            frame_phase_d = phase_q;
            if (frame_cnt_q == FCW'(BLINK_FRAMES - 1)) begin
                frame_cnt_d = '0;
                phase_d     = ~phase_q;
            end else begin
                frame_cnt_d = frame_cnt_q + FCW'(1);
            end
            // Only a load from an earlier cycle moves across; a coincident load
            // keeps pend_valid set and waits for the following boundary.
            if (pend_valid_q) begin
                act_digits_d = pend_digits_q;
                act_dp_d     = pend_dp_q;
                act_blink_d  = pend_blink_q;
                if (!load) begin
                    pend_valid_d = 1'b0;
                end
            end
        end

        if (tick) begin
            nib = act_digits_d[{idx_d, 2'b00} +: 4];
            for (int j = 0; j < NUM_DIGITS; j++) begin
                if (j >= int'(idx_d) && act_digits_d[4*j +: 4] != 4'd0) begin
                    upper_zero = 1'b0;
                end
            end
            slot_blank = (nib > BCD_MAX)
                      || (lz_blank && idx_d != 2'd0 && upper_zero)
                      || (act_blink_d[idx_d] && frame_phase_d);
            bcd_d   = nib;
            blank_d = slot_blank;
            dp_d    = !slot_blank && act_dp_d[idx_d];
            an_d    = slot_blank ? AN_ALL_OFF : slot_to_an(idx_d);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q         <= 2'd3;
            pend_digits_q <= '0;
            pend_dp_q     <= '0;
            pend_blink_q  <= '0;
            pend_valid_q  <= 1'b0;
            act_digits_q  <= '0;
            act_dp_q      <= '0;
            act_blink_q   <= '0;
            frame_cnt_q   <= '0;
            phase_q       <= 1'b0;
            frame_phase_q <= 1'b0;
            bcd_q         <= 4'd0;
            blank_q       <= 1'b1;
            dp_q          <= 1'b0;
            an_q          <= AN_ALL_OFF;
            frame_start_q <= 1'b0;
        end else begin
            idx_q         <= idx_d;
            pend_digits_q <= pend_digits_d;
            pend_dp_q     <= pend_dp_d;
            pend_blink_q  <= pend_blink_d;
            pend_valid_q  <= pend_valid_d;
            act_digits_q  <= act_digits_d;
            act_dp_q      <= act_dp_d;
            act_blink_q   <= act_blink_d;
            frame_cnt_q   <= frame_cnt_d;
            phase_q       <= phase_d;
            frame_phase_q <= frame_phase_d;
            bcd_q         <= bcd_d;
            blank_q       <= blank_d;
            dp_q          <= dp_d;
            an_q          <= an_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign bcd_out     = bcd_q;
    assign blank_out   = blank_q;
    assign dp_out      = dp_q;
    assign an          = an_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Bench for seven_seg_scanner: every cycle is checked against a frame-level model,
// plus a slot table and hand-written blink, load-timing and reset sequences.
module tb_seven_seg_scanner;

    localparam int RD = 4;
    localparam int BF = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] digits_in = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  blink_in = '0;
    logic        lz_blank = 1'b0;
    logic        load = 1'b0;
    logic [3:0]  bcd_out;
    logic        blank_out;
    logic        dp_out;
    logic [3:0]  an;
    logic        frame_start;

    seven_seg_scanner #(
        .REFRESH_DIV  (RD),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .digits_in   (digits_in),
        .dp_in       (dp_in),
        .blink_in    (blink_in),
        .lz_blank    (lz_blank),
        .load        (load),
        .bcd_out     (bcd_out),
        .blank_out   (blank_out),
        .dp_out      (dp_out),
        .an          (an),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Model state: rising edges since reset release, loads seen, lz at last tick.
    typedef struct {
        int          e;
        logic [15:0] d;
        logic [3:0]  dp;
        logic [3:0]  bl;
    } load_t;
    load_t load_q[$];
    int    edge_cnt = 0;
    logic  lz_tick = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Expected {bcd, blank, dp, an, frame_start} from frame/slot arithmetic.
    function automatic logic [10:0] model_exp();
        int n, idx, f, eb, ph;
        logic [15:0] d;
        logic [15:0] upper;
        logic [3:0]  dpm, blm, nib, an_e;
        logic        blank, lzb;
        if (edge_cnt < RD) return {4'h0, 1'b1, 1'b0, 4'hF, 1'b0};
        n   = edge_cnt / RD;
        idx = (n + 3) % 4;
        f   = (n - 1) / 4;
        eb  = (4 * f + 1) * RD;
        ph  = (f / BF) % 2;
        d = '0; dpm = '0; blm = '0;
        for (int i = 0; i < load_q.size(); i++) begin
            if (load_q[i].e < eb) begin
                d = load_q[i].d; dpm = load_q[i].dp; blm = load_q[i].bl;
            end
        end
        upper = d >> (4 * idx);
        nib   = upper[3:0];
        lzb   = lz_tick && (idx >= 1) && (upper == 16'h0);
        blank = (nib > 4'd9) || lzb || (blm[idx] && ph == 1);
        an_e  = blank ? 4'hF : ~(4'b0001 << idx);
        return {nib, blank, (!blank) && dpm[idx], an_e, edge_cnt == eb};
    endfunction

    task automatic cycle();
        load_t r;
        @(posedge clk);
        if (!reset) begin
            edge_cnt++;
            if (load) begin
                r.e = edge_cnt; r.d = digits_in; r.dp = dp_in; r.bl = blink_in;
                load_q.push_back(r);
            end
            if (edge_cnt % RD == 0) lz_tick = lz_blank;
        end
        #1;
        check("model", {21'd0, bcd_out, blank_out, dp_out, an, frame_start}, {21'd0, model_exp()});
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic wait_frame();
        int c;
        c = 0;
        do begin
            cycle();
            c++;
        end while (frame_start !== 1'b1 && c < 40);
        check("frame_start_seen", {31'd0, frame_start}, 32'd1);
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl);
        digits_in = d; dp_in = dp; blink_in = bl; load = 1'b1;
        cycle();
        load = 1'b0;
    endtask

    typedef struct packed {
        logic [15:0] digits;
        logic [3:0]  dp;
        logic        lz;
        logic [15:0] an_exp;
        logic [3:0]  blank_exp;
        logic [3:0]  dp_exp;
    } vec_t;
    vec_t tbl[7];

    initial begin
        tbl[0] = '{16'h1234, 4'b0000, 1'b0, 16'h7BDE, 4'b0000, 4'b0000};
        tbl[1] = '{16'h0070, 4'b0000, 1'b1, 16'hFFDE, 4'b1100, 4'b0000};
        tbl[2] = '{16'h0070, 4'b0101, 1'b0, 16'h7BDE, 4'b0000, 4'b0101};
        tbl[3] = '{16'h00A5, 4'b0010, 1'b0, 16'h7BFE, 4'b0010, 4'b0000};
        tbl[4] = '{16'h9000, 4'b1000, 1'b1, 16'h7BDE, 4'b0000, 4'b1000};
        tbl[5] = '{16'h0000, 4'b1111, 1'b1, 16'hFFFE, 4'b1110, 4'b0001};
        tbl[6] = '{16'hF0F0, 4'b0000, 1'b0, 16'hFBFE, 4'b1010, 4'b0000};

        // Reset values
        cycles(2);
        check("reset_outputs", {21'd0, bcd_out, blank_out, dp_out, an, frame_start},
              {21'd0, 4'h0, 1'b1, 1'b0, 4'hF, 1'b0});
        reset = 1'b0;

        // Blink on digit 0, loaded before the first boundary so it is frame 0.
        load = 1'b1; digits_in = 16'h8888; dp_in = 4'b0000; blink_in = 4'b0001;
        cycle();
        load = 1'b0;
        for (int f = 0; f < 6; f++) begin
            wait_frame();
            check("blink_slot0", {31'd0, blank_out}, {31'd0, (f % 4) >= 2});
            cycles(4);
            check("blink_slot1_lit", {27'd0, blank_out, an}, {27'd0, 1'b0, 4'b1101});
        end

        // Slot table
        for (int i = 0; i < 7; i++) begin
            lz_blank = tbl[i].lz;
            do_load(tbl[i].digits, tbl[i].dp, 4'b0000);
            wait_frame();
            for (int k = 0; k < 4; k++) begin
                check($sformatf("table%0d_slot%0d", i, k),
                      {22'd0, bcd_out, blank_out, dp_out, an},
                      {22'd0, tbl[i].digits[4*k +: 4], tbl[i].blank_exp[k],
                       tbl[i].dp_exp[k], tbl[i].an_exp[4*k +: 4]});
                if (k < 3) cycles(4);
            end
        end
        lz_blank = 1'b0;

        // Mid-frame loads: last one wins, shown only from the next frame.
        do_load(16'h9999, 4'b0000, 4'b0000);
        wait_frame();
        cycles(5);
        do_load(16'h1111, 4'b0000, 4'b0000);
        cycles(1);
        do_load(16'h2222, 4'b0000, 4'b0000);
        cycles(4);
        check("midframe_unchanged", {28'd0, bcd_out}, 32'd9);
        wait_frame();
        check("midframe_next", {28'd0, bcd_out}, 32'd2);

        // Load coincident with a boundary is deferred one frame.
        cycles(4 * RD - 1);
        do_load(16'h3333, 4'b0000, 4'b0000);
        check("coincident_fs", {31'd0, frame_start}, 32'd1);
        check("coincident_old", {28'd0, bcd_out}, 32'd2);
        wait_frame();
        check("coincident_new", {28'd0, bcd_out}, 32'd3);

        // Reset during slot 2 with a pending load that must be discarded.
        cycles(2 * RD - 1);
        do_load(16'h5555, 4'b0000, 4'b0000);
        check("pre_reset_slot2", {28'd0, an}, 32'hB);
        #3;
        reset = 1'b1;
        edge_cnt = 0;
        load_q.delete();
        #1;
        check("async_reset_dark", {21'd0, bcd_out, blank_out, dp_out, an, frame_start},
              {21'd0, 4'h0, 1'b1, 1'b0, 4'hF, 1'b0});
        @(negedge clk);
        cycles(2);
        reset = 1'b0;
        cycles(RD - 1);
        check("post_reset_no_fs", {31'd0, frame_start}, 32'd0);
        cycle();
        check("post_reset_fs", {23'd0, frame_start, bcd_out, an}, {23'd0, 1'b1, 4'h0, 4'hE});
        wait_frame();
        check("post_reset_zero", {27'd0, blank_out, bcd_out}, 32'd0);

        // Randomized traffic checked by the model every cycle.
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 19) == 0) begin
                for (int j = 0; j < 4; j++)
                    digits_in[4*j +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
                dp_in    = 4'($urandom_range(0, 15));
                blink_in = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
                load     = 1'b1;
            end else begin
                load = 1'b0;
            end
            if ($urandom_range(0, 149) == 0) lz_blank = ~lz_blank;
            cycle();
        end
        load = 1'b0;
        cycles(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
